ms_seq_ctrl: RTL and testbench

- Sequential controller for the multiply-subtract datapath: computes res = (x*y) - z over several clock cycles and produces the 4-bit status word alongside.
- Uses one shift-add adder, iterated once per multiplier bit, instead of a combinational array multiplier.
- Sits between the instruction/issue logic and the register write-back, using a start/busy/done handshake.

---
 rtl/ms_pkg.sv | 19 +
 rtl/ms_seq_ctrl_if.sv | 27 ++
 rtl/ms_status_gen.sv | 29 ++
 rtl/ms_seq_ctrl.sv | 104 ++++++++++
 tb/tb_ms_seq_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/ms_pkg.sv
// Shared definitions for the multiply-subtract sequencer and its consumers:
// FSM state encoding and status-word bit positions.
package ms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Status word layout {N, B, C, Z}; write-back decodes with the same indices.
  localparam int ST_Z = 0;
  localparam int ST_C = 1;
  localparam int ST_B = 2;
  localparam int ST_N = 3;
  localparam int ST_W = 4;

endpackage

// File: rtl/ms_seq_ctrl_if.sv
// Issue-side handshake and result bus of the multiply-subtract sequencer.
// master = issue/write-back logic, slave = ms_seq_ctrl.
interface ms_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  import ms_pkg::*;

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [ST_W-1:0]  st;

  modport master (
    output start, x, y, z,
    input  busy, done, res, st
  );

  modport slave (
    input  start, x, y, z,
    output busy, done, res, st
  );

endinterface

// File: rtl/ms_status_gen.sv
// Combinational result/status generation from the finished product P and
// the latched subtrahend z. Registered by the sequencer in its SUB state.
module ms_status_gen
  import ms_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   z,
  output logic [WIDTH-1:0]   res,
  output logic [ST_W-1:0]    st
);

  logic [2*WIDTH-1:0] z_ext;

  assign z_ext = {{WIDTH{1'b0}}, z};

  // The low half of P - z only depends on the low half of P, so the
  // narrow subtract gives the truncated result directly.
  always_comb begin
    res       = p[WIDTH-1:0] - z;
    st        = '0;
    st[ST_Z]  = (res == '0);
    st[ST_C]  = |p[2*WIDTH-1:WIDTH];
    st[ST_B]  = (p < z_ext);
    st[ST_N]  = res[WIDTH-1];
  end

endmodule

// File: rtl/ms_seq_ctrl.sv
// Sequential multiply-subtract controller: res = x*y - z using one
// shift-add step per multiplier bit, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// MUL   | one shift-add per multiplier bit, WIDTH edges, no early exit
// SUB   | register res/st from the finished product
// DONE  | done pulse for one cycle, then back to IDLE
module ms_seq_ctrl
  import ms_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  ms_seq_ctrl_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   z_q;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] addend;
  logic               last_bit;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_c;
  logic [ST_W-1:0]    st_q;
  logic [ST_W-1:0]    st_c;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign addend   = {{WIDTH{1'b0}}, x_q} << cnt;

  ms_status_gen #(.WIDTH(WIDTH)) u_status (
    .p   (p),
    .z   (z_q),
    .res (res_c),
    .st  (st_c)
  );

  // State register; reset abandons any computation in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: fixed-length walk IDLE -> MUL x WIDTH -> SUB -> DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = MUL;
      MUL:     if (last_bit)  state_nxt = SUB;
      SUB:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state, so done is glitch-free.
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
    bus.res  = res_q;
    bus.st   = st_q;
  end

  // Operand latches, shift-add accumulator, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      p     <= '0;
      res_q <= '0;
      st_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_q <= bus.x;
            y_q <= bus.y;
            z_q <= bus.z;
            p   <= '0;
            cnt <= '0;
          end
        end
        MUL: begin
          if (y_q[cnt]) p <= p + addend;
          cnt <= cnt + 1'b1;
        end
        SUB: begin
          res_q <= res_c;
          st_q  <= st_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_seq_ctrl.sv
// Randomized scoreboard bench for ms_seq_ctrl. The driver decides from a
// timing model whether each start is accepted and queues the arithmetic
// result; a monitor checks busy/done timing and pops results on done.
module tb_ms_seq_ctrl;
  import ms_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   st;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ms_seq_ctrl_if #(.WIDTH(W)) bus ();

  ms_seq_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge number of the most recent accepted start; far past means idle.
  int   acc    = -1000;
  int   checks = 0;
  int   passed = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, got, want);
  endtask

  function automatic exp_t model(input int xv, input int yv, input int zv, input int a);
    exp_t e;
    int prod;
    int diff;
    logic [31:0] d;
    prod = xv * yv;
    diff = prod - zv;
    d = diff;
    e.res = d[W-1:0];
    e.st  = {e.res[W-1], (prod < zv), (prod > 255), (e.res == 0)};
    e.acc = a;
    return e;
  endfunction

  // One cycle of stimulus, driven at the falling edge for the next rising edge.
  task automatic step(input logic s, input logic [W-1:0] xv, input logic [W-1:0] yv,
                      input logic [W-1:0] zv);
    @(negedge clk);
    bus.start = s;
    bus.x     = xv;
    bus.y     = yv;
    bus.z     = zv;
    if (s && !rst && cyc >= acc + 10) begin
      acc = cyc + 1;
      q.push_back(model(xv, yv, zv, acc));
    end
  endtask

  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic [W-1:0] zv, input bit noisy);
    step(1'b1, xv, yv, zv);
    repeat (10)
      step(noisy ? 1'($urandom_range(0, 1)) : 1'b0,
           W'($urandom), W'($urandom), W'($urandom));
  endtask

  // Monitor: sample just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("busy", 32'(bus.busy), 32'(cyc >= acc && cyc <= acc + 9));
      if (bus.done || cyc == acc + 9) begin
        check("done", 32'(bus.done), 32'(cyc == acc + 9));
        if (bus.done && q.size() > 0) begin
          e = q.pop_front();
          check("res", 32'(bus.res), 32'(e.res));
          check("st", 32'(bus.st), 32'(e.st));
          check("latency", cyc, e.acc + 9);
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    bus.z     = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_res", 32'(bus.res), 32'h0);
    check("reset_st", 32'(bus.st), 32'h0);
    rst = 1'b0;

    run_op(8'h01, 8'h01, 8'h02, 1'b0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0);
    run_op(8'h00, 8'h00, 8'h01, 1'b0);
    run_op(8'h03, 8'h56, 8'h01, 1'b0);
    run_op(8'h03, 8'h55, 8'h0C, 1'b1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b1);

    for (int i = 0; i < 25; i++) begin
      if (i % 3 == 0)
        run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), W'($urandom), 1'b1);
      else
        run_op(W'($urandom), W'($urandom), W'($urandom), 1'b1);
    end

    // start held high: back-to-back accepts every WIDTH+3 cycles
    for (int i = 0; i < 55; i++)
      step(1'b1, W'($urandom), W'($urandom), W'($urandom));
    repeat (12) step(1'b0, W'($urandom), W'($urandom), W'($urandom));

    // nonzero result held before the abort
    run_op(8'h07, 8'h05, 8'h01, 1'b0);

    // reset lands on MUL iteration 4
    step(1'b1, 8'h0F, 8'h0F, 8'h03);
    repeat (4) step(1'b0, W'($urandom), W'($urandom), W'($urandom));
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b0;
    acc       = -1000;
    if (q.size() > 0) q.pop_back();
    @(negedge clk);
    check("abort_res", 32'(bus.res), 32'h0);
    check("abort_st", 32'(bus.st), 32'h0);
    rst = 1'b0;

    run_op(8'h02, 8'h03, 8'h01, 1'b0);
    repeat (3) step(1'b0, '0, '0, '0);

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
